hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It produces the load-enable and zero (bubble) controls for PC, IF/ID, ID/EX and EX/MEM, and resolves load-use hazards, taken branch/jump flushes and syscall halt/resume. It also keeps saturating performance counters for total cycles, stall cycles and flushes. It sits beside the decode stage and drives the `stall` (capture enable, 1 = load) and `zero` ports of the stage registers.

Parameters:
- CNT_BITS, 32, width of each performance counter.
- REG_BITS, 5, register-number width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  REG_BITS  rs field of the instruction in ID.
- id_rt  in  REG_BITS  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_MemToReg  in  1  EX instruction is a load.
- ex_RegWrite  in  1  EX instruction writes the register file.
- ex_wreg  in  REG_BITS  destination register of the EX instruction.
- ex_taken  in  1  branch or jump resolved taken in EX (Jmp/Jal/Jr, or a satisfied Beq/Bne/Bltz/Blez/Bgez/Bgtz).
- ex_halt  in  1  EX instruction is a syscall with halt code.
- resume  in  1  single-cycle pulse that leaves HALT.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID capture enable.
- ifid_zero  out  1  IF/ID clear.
- idex_en  out  1  ID/EX capture enable (drives ID_EX `stall`).
- idex_zero  out  1  ID/EX clear (drives ID_EX `zero`).
- exmem_en  out  1  EX/MEM capture enable.
- halted  out  1  high while in HALT.
- cycle_cnt  out  CNT_BITS  cycles spent in RUN.
- stall_cnt  out  CNT_BITS  load-use stall cycles.
- flush_cnt  out  CNT_BITS  taken-branch flush events.

Behaviour:
- State register with states RUN and HALT. Reset state is RUN. Counters reset to 0. Asynchronous reset applies immediately.
- While rst is high, all *_en outputs are 0, ifid_zero = idex_zero = 1, and halted = 0.
- Enable and zero outputs are combinational from state and inputs, so they take effect at the same clock edge. halted and the counters are registered.
- Load-use hazard: lu = ex_MemToReg & ex_RegWrite & (ex_wreg != 0) & ((id_uses_rs & id_rs == ex_wreg) | (id_uses_rt & id_rt == ex_wreg)).
- Priority in RUN: ex_halt > ex_taken > lu > normal.
  - Normal: pc_en, ifid_en, idex_en and exmem_en are 1; both zeros are 0.
  - ex_taken: pc_en = 1 (target load), ifid_zero = 1, idex_zero = 1, exmem_en = 1. This inserts 2 bubbles. flush_cnt increments.
  - lu: pc_en = 0, ifid_en = 0, idex_zero = 1, exmem_en = 1. This inserts 1 bubble; the ID instruction re-decodes next cycle. stall_cnt increments.
  - ex_halt: pc_en = 0, ifid_en = 0, idex_zero = 1, exmem_en = 1, so the syscall drains forward. Next state is HALT.
- A zero has priority over an enable inside the stage register. The controller never asserts both for the same stage.
- HALT: all *_en = 0, all zeros = 0, so the pipeline is frozen with contents intact. halted = 1. No counter increments.
  - resume in HALT: next state is RUN. Outputs in that cycle stay frozen; normal issue begins the following cycle.
  - resume in RUN is ignored.
- ex_taken together with lu: the flush wins and stall_cnt does not increment, because the hazarding ID instruction is squashed.
- ex_halt together with ex_taken cannot legally occur. If it does, halt wins and flush_cnt does not increment.
- cycle_cnt increments on every RUN cycle, including stall and flush cycles.
- All counters saturate at 2^CNT_BITS-1 and do not wrap.
- A reset asserted mid-stall or mid-HALT returns to RUN with counters at 0. No pending hazard state is retained; lu is purely combinational.
- Register 0 is never a hazard source.

Decomposition:
- Package hazard_pkg holds the state encoding (RUN = 1'b0, HALT = 1'b1) and the zero-register constant.
- Sub-module sat_counter (CNT_BITS, inc, clear via rst, saturating) is instantiated 3 times.
- Priority and enable logic stay inline in hazard_ctrl.

Test Plan:
- Reset then 10 idle cycles → all en = 1, zeros = 0, cycle_cnt = 10, stall_cnt = 0, flush_cnt = 0.
- ex_MemToReg = 1, ex_RegWrite = 1, ex_wreg = 8, id_rs = 8, id_uses_rs = 1 for 1 cycle → pc_en = 0, ifid_en = 0, idex_zero = 1, exmem_en = 1, stall_cnt = 1. Repeat with ex_wreg = 0 → no stall.
- ex_taken = 1 for 1 cycle → pc_en = 1, ifid_zero = 1, idex_zero = 1, flush_cnt = 1. Then ex_taken plus a load-use match on the same cycle → flush outputs only, stall_cnt unchanged.
- ex_halt pulse → that cycle: idex_zero = 1, exmem_en = 1. Next 5 cycles: halted = 1, all en = 0, cycle_cnt frozen. resume pulse → halted = 0 one cycle later, en = 1 on the following cycle.
- rst asserted asynchronously mid-HALT → immediately halted = 0, idex_zero = 1, and counters = 0 without waiting for a clock edge.
- CNT_BITS = 4 with 20 RUN cycles → cycle_cnt holds 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the pipeline sequencer
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
  localparam int unsigned ZERO_REG = 0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [CNT_BITS-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stage-register enables/bubbles for load-use, flush and syscall halt
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_BITS = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_MemToReg,
  input  logic                ex_RegWrite,
  input  logic [REG_BITS-1:0] ex_wreg,
  input  logic                ex_taken,
  input  logic                ex_halt,
  input  logic                resume,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_zero,
  output logic                idex_en,
  output logic                idex_zero,
  output logic                exmem_en,
  output logic                halted,
  output logic [CNT_BITS-1:0] cycle_cnt,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] flush_cnt
);
  state_t state;
  logic run, lu, do_halt, do_flush, do_stall, do_norm;
  assign lu = ex_MemToReg && ex_RegWrite && (ex_wreg != REG_BITS'(ZERO_REG)) &&
              ((id_uses_rs && id_rs == ex_wreg) || (id_uses_rt && id_rt == ex_wreg));
  assign run      = (state == RUN);
  assign do_halt  = run && ex_halt;
  assign do_flush = run && !ex_halt && ex_taken;
  assign do_stall = run && !ex_halt && !ex_taken && lu;
  assign do_norm  = run && !ex_halt && !ex_taken && !lu;
  // rst forces every stage to bubble without waiting for the state register
  assign pc_en     = !rst && (do_norm || do_flush);
  assign ifid_en   = !rst && do_norm;
  assign ifid_zero = rst || do_flush;
  assign idex_en   = !rst && do_norm;
  assign idex_zero = rst || do_halt || do_flush || do_stall;
  assign exmem_en  = !rst && run;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (run && ex_halt) begin
      state  <= HALT;
      halted <= 1'b1;
    end else if (!run && resume) begin
      state  <= RUN;
      halted <= 1'b0;
    end
  sat_counter #(.CNT_BITS(CNT_BITS)) u_cycle (.clk(clk), .rst(rst), .inc(run),      .q(cycle_cnt));
  sat_counter #(.CNT_BITS(CNT_BITS)) u_stall (.clk(clk), .rst(rst), .inc(do_stall), .q(stall_cnt));
  sat_counter #(.CNT_BITS(CNT_BITS)) u_flush (.clk(clk), .rst(rst), .inc(do_flush), .q(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven vectors with a scoreboard queue for hazard_ctrl
module tb_hazard_ctrl;
  typedef struct {
    logic [4:0] rs, rt, wreg;
    logic urs, urt, mtr, rw, tk, hl, rsm;
  } in_t;
  typedef struct {
    in_t        i;
    logic [5:0] ctl;
  } vec_t;
  typedef struct {
    logic [5:0]  ctl;
    logic        halted;
    logic [31:0] cyc, stl, fl;
    logic [3:0]  cyc4;
  } exp_t;
  localparam logic [5:0] NORM = 6'b110101, FLUSH = 6'b101011, BUB = 6'b000011,
                         FROZ = 6'b000000, RSTV = 6'b001010;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic id_uses_rs, id_uses_rt, ex_MemToReg, ex_RegWrite, ex_taken, ex_halt, resume;
  logic pc_en, ifid_en, ifid_zero, idex_en, idex_zero, exmem_en, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  logic pc_en4, ifid_en4, ifid_zero4, idex_en4, idex_zero4, exmem_en4, halted4;
  logic [3:0] cycle_cnt4, stall_cnt4, flush_cnt4;
  exp_t q[$];
  vec_t tbl[10];
  int checks = 0, errors = 0;
  logic m_halted = 0;
  logic [31:0] m_cyc = 0, m_stl = 0, m_fl = 0;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_MemToReg(ex_MemToReg), .ex_RegWrite(ex_RegWrite),
    .ex_wreg(ex_wreg), .ex_taken(ex_taken), .ex_halt(ex_halt), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_zero(ifid_zero), .idex_en(idex_en),
    .idex_zero(idex_zero), .exmem_en(exmem_en), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  hazard_ctrl #(.CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_MemToReg(ex_MemToReg), .ex_RegWrite(ex_RegWrite),
    .ex_wreg(ex_wreg), .ex_taken(ex_taken), .ex_halt(ex_halt), .resume(resume),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_zero(ifid_zero4), .idex_en(idex_en4),
    .idex_zero(idex_zero4), .exmem_en(exmem_en4), .halted(halted4),
    .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));
  function automatic in_t mk(logic [4:0] rs, rt, logic urs, urt, mtr, rw,
                             logic [4:0] wreg, logic tk, hl, rsm);
    in_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mtr = mtr; v.rw = rw;
    v.wreg = wreg; v.tk = tk; v.hl = hl; v.rsm = rsm;
    return v;
  endfunction
  task automatic apply(in_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_MemToReg = v.mtr; ex_RegWrite = v.rw; ex_wreg = v.wreg;
    ex_taken = v.tk; ex_halt = v.hl; resume = v.rsm;
  endtask
  task automatic push(logic [5:0] ctl);
    exp_t e;
    e.ctl = ctl; e.halted = m_halted; e.cyc = m_cyc; e.stl = m_stl; e.fl = m_fl;
    e.cyc4 = (m_cyc > 15) ? 4'd15 : m_cyc[3:0];
    q.push_back(e);
  endtask
  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic check_pop(string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    cmp({tag, ".ctl"}, 32'({pc_en, ifid_en, ifid_zero, idex_en, idex_zero, exmem_en}), 32'(e.ctl));
    cmp({tag, ".halted"}, 32'(halted), 32'(e.halted));
    cmp({tag, ".cycle_cnt"}, cycle_cnt, e.cyc);
    cmp({tag, ".stall_cnt"}, stall_cnt, e.stl);
    cmp({tag, ".flush_cnt"}, flush_cnt, e.fl);
    cmp({tag, ".cycle_cnt4"}, 32'(cycle_cnt4), 32'(e.cyc4));
  endtask
  task automatic step(string tag, in_t v, logic [5:0] ctl);
    apply(v);
    push(ctl);
    @(negedge clk);
    check_pop(tag);
    @(posedge clk);
    if (!m_halted) begin
      m_cyc++;
      if (ctl == FLUSH) m_fl++;
      if (ctl == BUB && !v.hl) m_stl++;
      if (v.hl) m_halted = 1;
    end else if (v.rsm) m_halted = 0;
    #1;
  endtask
  in_t idle;
  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{mk(8, 0, 1, 0, 1, 1, 8, 0, 0, 0), BUB};
    tbl[1] = '{mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0), NORM};
    tbl[2] = '{mk(1, 5, 1, 1, 1, 1, 5, 0, 0, 0), BUB};
    tbl[3] = '{mk(1, 5, 1, 0, 1, 1, 5, 0, 0, 0), NORM};
    tbl[4] = '{mk(9, 0, 1, 0, 0, 1, 9, 0, 0, 0), NORM};
    tbl[5] = '{mk(9, 0, 1, 0, 1, 0, 9, 0, 0, 0), NORM};
    tbl[6] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), FLUSH};
    tbl[7] = '{mk(7, 0, 1, 0, 1, 1, 7, 1, 0, 0), FLUSH};
    tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), NORM};
    tbl[9] = '{mk(3, 4, 1, 1, 1, 1, 31, 0, 0, 0), NORM};
    apply(idle);
    #2;
    push(RSTV);
    check_pop("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) step("idle", idle, NORM);
    for (int i = 0; i < 10; i++) step($sformatf("vec%0d", i), tbl[i].i, tbl[i].ctl);
    step("halt", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), BUB);
    for (int i = 0; i < 5; i++) step("frozen", idle, FROZ);
    step("resume", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), FROZ);
    step("after_resume", idle, NORM);
    step("halt_taken", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), BUB);
    step("frozen2", idle, FROZ);
    rst = 1;
    m_halted = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
    #1;
    push(RSTV);
    check_pop("async_rst");
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 20; i++) step("sat", idle, NORM);
    push(NORM);
    @(negedge clk);
    check_pop("sat_end");
    cmp("cycle_cnt4_sat", 32'(cycle_cnt4), 32'd15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
